// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART controller: register map, status/control bit
// positions and TX sequencer state encoding.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_EMPTY   = 2;
    localparam int unsigned ST_RX_FULL    = 3;
    localparam int unsigned ST_RX_OVERRUN = 4;
    localparam int unsigned ST_FRAME_ERR  = 5;
    localparam int unsigned ST_TX_DROP    = 6;
    localparam int unsigned ST_TX_BUSY    = 7;

    localparam int unsigned CTRL_TX_EN = 0;
    localparam int unsigned CTRL_RX_IE = 1;
    localparam int unsigned CTRL_TX_IE = 2;

    localparam logic [7:0] CONTROL_RST = 8'h01;

    typedef enum logic [1:0] {
        TxIdle,
        TxWaitBusy,
        TxWaitDone
    } tx_state_e;

endpackage

// File: rtl/uart_ctrl_sync_fifo.sv
// Synchronous FIFO with combinational head output. A pop on a full FIFO frees
// the slot for a push in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// CPU-facing UART controller: TX/RX FIFOs, DATA/STATUS/CONTROL registers,
// sticky error flags, level interrupt and the TX pacing sequencer.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TX_AW = 4,
    parameter int unsigned RX_AW = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_addr,
    input  logic       i_wr_en,
    input  logic       i_rd_en,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_irq,
    output logic       o_uart_transmit,
    output logic [7:0] o_uart_tx_byte,
    input  logic       i_uart_is_transmitting,
    input  logic       i_uart_received,
    input  logic [7:0] i_uart_rx_byte,
    input  logic       i_uart_recv_error
);
    tx_state_e   r_state;
    logic        r_transmit;
    logic [7:0]  r_tx_byte;
    logic [7:0]  r_rdata;
    logic        r_irq;
    logic [2:0]  r_ctrl;
    logic        r_rx_overrun;
    logic        r_frame_err;
    logic        r_tx_drop;

    logic [7:0]   w_tx_dout;
    logic         w_tx_full;
    logic         w_tx_empty;
    logic [TX_AW:0] w_tx_count;
    logic [7:0]   w_rx_dout;
    logic         w_rx_full;
    logic         w_rx_empty;
    logic [RX_AW:0] w_rx_count;

    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_stat_wr;
    logic       w_ctrl_wr;
    logic       w_tx_start;
    logic       w_rx_pop;
    logic       w_tx_busy;
    logic [7:0] w_status;
    logic [7:0] w_rd_val;

    assign w_data_wr  = i_wr_en & (i_addr == ADDR_DATA);
    assign w_data_rd  = i_rd_en & (i_addr == ADDR_DATA);
    assign w_stat_wr  = i_wr_en & (i_addr == ADDR_STATUS);
    assign w_ctrl_wr  = i_wr_en & (i_addr == ADDR_CONTROL);
    assign w_rx_pop   = w_data_rd & ~w_rx_empty;
    assign w_tx_busy  = (r_state != TxIdle);
    // The FIFO pop and the registered pulse happen on the same edge.
    assign w_tx_start = (r_state == TxIdle) & r_ctrl[CTRL_TX_EN] & ~w_tx_empty;

    sync_fifo #(
        .WIDTH (8),
        .AW    (TX_AW)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_data_wr),
        .i_pop   (w_tx_start),
        .i_din   (i_wdata),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .AW    (RX_AW)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_uart_received),
        .i_pop   (w_rx_pop),
        .i_din   (i_uart_rx_byte),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_status                = '0;
        w_status[ST_TX_FULL]    = w_tx_full;
        w_status[ST_TX_EMPTY]   = w_tx_empty;
        w_status[ST_RX_EMPTY]   = w_rx_empty;
        w_status[ST_RX_FULL]    = w_rx_full;
        w_status[ST_RX_OVERRUN] = r_rx_overrun;
        w_status[ST_FRAME_ERR]  = r_frame_err;
        w_status[ST_TX_DROP]    = r_tx_drop;
        w_status[ST_TX_BUSY]    = w_tx_busy;
    end

    always_comb begin
        w_rd_val = '0;
        case (i_addr)
            ADDR_DATA:    w_rd_val = w_rx_empty ? 8'h00 : w_rx_dout;
            ADDR_STATUS:  w_rd_val = w_status;
            ADDR_CONTROL: w_rd_val = {5'b0, r_ctrl};
            default:      w_rd_val = '0;
        endcase
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata      <= '0;
            r_irq        <= 1'b0;
            r_ctrl       <= CONTROL_RST[2:0];
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tx_drop    <= 1'b0;
        end else begin
            if (i_rd_en) begin
                r_rdata <= w_rd_val;
            end
            if (w_ctrl_wr) begin
                r_ctrl <= i_wdata[2:0];
            end
            r_rx_overrun <= (r_rx_overrun & ~(w_stat_wr & i_wdata[ST_RX_OVERRUN]))
                          | (i_uart_received & w_rx_full & ~w_rx_pop);
            r_frame_err  <= (r_frame_err & ~(w_stat_wr & i_wdata[ST_FRAME_ERR]))
                          | i_uart_recv_error;
            r_tx_drop    <= (r_tx_drop & ~(w_stat_wr & i_wdata[ST_TX_DROP]))
                          | (w_data_wr & w_tx_full & ~w_tx_start);
            r_irq        <= (r_ctrl[CTRL_RX_IE] & ~w_rx_empty)
                          | (r_ctrl[CTRL_TX_IE] & w_tx_empty & ~w_tx_busy);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= TxIdle;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_transmit <= 1'b0;
            case (r_state)
                TxIdle: begin
                    if (w_tx_start) begin
                        r_tx_byte  <= w_tx_dout;
                        r_transmit <= 1'b1;
                        r_state    <= TxWaitBusy;
                    end
                end
                TxWaitBusy: begin
                    if (i_uart_is_transmitting) begin
                        r_state <= TxWaitDone;
                    end
                end
                TxWaitDone: begin
                    if (!i_uart_is_transmitting) begin
                        r_state <= TxIdle;
                    end
                end
                default: r_state <= TxIdle;
            endcase
        end
    end

    assign o_rdata         = r_rdata;
    assign o_irq           = r_irq;
    assign o_uart_transmit = r_transmit;
    assign o_uart_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a small behavioural model of the uart core
// that raises busy the cycle after each transmit pulse.
module tb_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       irq;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       busy = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       recv_error = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [2:0] busy_cnt = '0;
    int         n_pulse = 0;
    logic [7:0] pulse_bytes [64];
    logic       prev_transmit = 1'b0;
    logic       viol = 1'b0;
    logic [7:0] last_byte = '0;
    logic [7:0] v;

    uart_ctrl dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_addr                 (addr),
        .i_wr_en                (wr_en),
        .i_rd_en                (rd_en),
        .i_wdata                (wdata),
        .o_rdata                (rdata),
        .o_irq                  (irq),
        .o_uart_transmit        (transmit),
        .o_uart_tx_byte         (tx_byte),
        .i_uart_is_transmitting (busy),
        .i_uart_received        (received),
        .i_uart_rx_byte         (rx_byte),
        .i_uart_recv_error      (recv_error)
    );

    always #5 clk = ~clk;

    // Core model: busy rises the cycle after the pulse and lasts five cycles.
    always @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            busy_cnt <= '0;
        end else if (transmit) begin
            busy     <= 1'b1;
            busy_cnt <= 3'd4;
        end else if (busy) begin
            if (busy_cnt == 0) busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // Pulse monitor: single-cycle pulses, never while busy, byte held during frame.
    always @(posedge clk) begin
        prev_transmit <= transmit;
        if (transmit && !rst) begin
            n_pulse              <= n_pulse + 1;
            pulse_bytes[n_pulse] <= tx_byte;
            last_byte            <= tx_byte;
            if (busy || prev_transmit) viol <= 1'b1;
        end
        if (busy && !rst && tx_byte !== last_byte) viol <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic rx(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1; rx_byte = b;
        @(negedge clk);
        received = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && n_pulse < n; i++) @(negedge clk);
        check("pulse_count", n_pulse, n);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_irq", irq, 1'b0);
        check("rst_transmit", transmit, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_rdata", rdata, 8'h00);
        rd(2'd1, v); check("rst_status", v, 8'h06);
        rd(2'd2, v); check("rst_control", v, 8'h01);

        // Two bytes out, paced by busy
        wr(2'd0, 8'h41);
        check("tx_no_pulse_n1", transmit, 1'b0);
        @(negedge clk);
        check("tx_pulse_n2", transmit, 1'b1);
        check("tx_byte_n2", tx_byte, 8'h41);
        wr(2'd0, 8'h42);
        wait_pulses(2, 200);
        check("tx_byte0", pulse_bytes[0], 8'h41);
        check("tx_byte1", pulse_bytes[1], 8'h42);
        rd(2'd1, v); check("tx_done_status", v, 8'h06);

        // TX FIFO overflow with tx_en cleared
        wr(2'd2, 8'h00);
        for (int i = 0; i < 17; i++) wr(2'd0, 8'(i));
        check("txen0_no_pulse", n_pulse, 2);
        rd(2'd1, v); check("tx_full_drop", v, 8'h45);
        wr(2'd1, 8'h40);
        rd(2'd1, v); check("tx_drop_clr", v, 8'h05);
        wr(2'd2, 8'h01);
        wait_pulses(18, 1000);
        check("tx_drain_first", pulse_bytes[2], 8'h00);
        check("tx_drain_last", pulse_bytes[17], 8'h0F);
        rd(2'd1, v); check("tx_drained", v, 8'h06);

        // RX overflow and in-order drain
        for (int i = 0; i < 17; i++) rx(8'(i));
        rd(2'd1, v); check("rx_full_ovr", v, 8'h1A);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, v); check($sformatf("rx_data%0d", i), v, 8'(i));
        end
        rd(2'd0, v); check("rx_empty_rd17", v, 8'h00);
        rd(2'd0, v); check("rx_empty_rd18", v, 8'h00);
        wr(2'd1, 8'h10);
        rd(2'd1, v); check("rx_ovr_clr", v, 8'h06);

        // Full RX FIFO: read coincident with receive
        for (int i = 0; i < 16; i++) rx(8'(8'h20 + i));
        @(negedge clk);
        addr = 2'd0; rd_en = 1'b1; received = 1'b1; rx_byte = 8'hAA;
        @(negedge clk);
        rd_en = 1'b0; received = 1'b0;
        check("rx_coinc_data", rdata, 8'h20);
        rd(2'd1, v); check("rx_coinc_status", v, 8'h0A);
        for (int i = 1; i < 16; i++) begin
            rd(2'd0, v); check($sformatf("rx_coinc%0d", i), v, 8'(8'h20 + i));
        end
        rd(2'd0, v); check("rx_coinc_last", v, 8'hAA);
        rd(2'd1, v); check("rx_coinc_empty", v, 8'h06);

        // Frame error and rx interrupt
        @(negedge clk); recv_error = 1'b1;
        @(negedge clk); recv_error = 1'b0;
        rd(2'd1, v); check("frame_err", v, 8'h26);
        wr(2'd2, 8'h03);
        @(negedge clk);
        check("irq_rx_empty", irq, 1'b0);
        rx(8'h55);
        @(negedge clk);
        check("irq_rx_set", irq, 1'b1);
        rd(2'd0, v); check("irq_rx_data", v, 8'h55);
        check("irq_hold", irq, 1'b1);
        @(negedge clk);
        check("irq_rx_clr", irq, 1'b0);
        wr(2'd1, 8'h20);
        rd(2'd1, v); check("frame_clr", v, 8'h06);

        // Set wins over simultaneous clear
        @(negedge clk);
        addr = 2'd1; wdata = 8'h20; wr_en = 1'b1; recv_error = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; recv_error = 1'b0;
        rd(2'd1, v); check("set_wins", v, 8'h26);
        wr(2'd1, 8'h20);

        // CONTROL masking, reserved address, tx interrupt
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'hFF);
        rd(2'd3, v); check("reserved_rd", v, 8'h00);
        rd(2'd2, v); check("ctrl_mask", v, 8'h07);
        check("irq_tx", irq, 1'b1);
        wr(2'd2, 8'h01);

        // Reset mid-frame
        wr(2'd0, 8'h77);
        @(negedge clk);
        check("mid_pulse", transmit, 1'b1);
        wr(2'd0, 8'h78);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_tx_byte", tx_byte, 8'h00);
        rd(2'd1, v); check("mid_status", v, 8'h06);
        rd(2'd2, v); check("mid_control", v, 8'h01);
        repeat (20) @(negedge clk);
        check("final_pulses", n_pulse, 19);
        check("pulse_rules", viol, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
